// File: rtl/dds_cfg_pkg.sv
// Shared encodings and constants for the DDS configuration controller.
package dds_cfg_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    COMMIT    = 2'd2
  } cfg_state_e;

  localparam logic [31:0] FTW_BASE_DEF = 32'd85899;

  // Phase step is a quarter turn: 2^(PHASE_W - PHASE_STEP_SHIFT)
  localparam int PHASE_STEP_SHIFT = 2;

  localparam int KEY_W = 0;
  localparam int KEY_A = 1;
  localparam int KEY_P = 2;
  localparam int KEY_F = 3;

endpackage

// File: rtl/dds_key_filter.sv
// Front-panel key conditioner: 2-flop synchronizer, debounce counter and
// one-shot accept that re-arms only after the synchronized input returns low.
module dds_key_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_acc
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      key_acc <= 1'b0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      key_acc <= 1'b0;
      // Counter saturates at DEB_CYCLES so a long hold yields a single accept
      if (!sync_p1) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(DEB_CYCLES)) begin
        cnt     <= cnt + 1'b1;
        key_acc <= (cnt == CNT_W'(DEB_CYCLES - 1));
      end
    end
  end

endmodule

// File: rtl/dds_cfg_ctrl.sv
// DDS configuration controller: shadows W/A/P/F key changes and commits them
// at an accumulator wrap. Optional auto frequency sweep under DDS_CFG_CTRL_SWEEP_EN.
module dds_cfg_ctrl
  import dds_cfg_pkg::*;
#(
  parameter int               DEB_CYCLES  = 4,
  parameter int               FTW_W       = 32,
  parameter int               PHASE_W     = 12,
  parameter logic [FTW_W-1:0] FTW_BASE    = FTW_W'(FTW_BASE_DEF),
  parameter int               WRAP_TO     = 65535
`ifdef DDS_CFG_CTRL_SWEEP_EN
  ,
  parameter int               SWEEP_WRAPS = 1000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               W_ctrl,
  input  logic               A_ctrl,
  input  logic               P_ctrl,
  input  logic               F_ctrl,
  input  logic               acc_wrap,
`ifdef DDS_CFG_CTRL_SWEEP_EN
  input  logic               sweep_en,
`endif
  output logic [1:0]         wave_sel,
  output logic [1:0]         amp_shift,
  output logic [PHASE_W-1:0] phase_word,
  output logic [FTW_W-1:0]   freq_word,
  output logic               cfg_upd,
  output logic               cfg_pending
);

  localparam int               TO_W       = $clog2(WRAP_TO + 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(WRAP_TO - 1);
  localparam logic [PHASE_W-1:0] PHASE_STEP = PHASE_W'(1) << (PHASE_W - PHASE_STEP_SHIFT);

  function automatic logic [1:0] sel_next(input logic [1:0] v);
    return v + 2'd1;
  endfunction

  function automatic logic [PHASE_W-1:0] phase_next(input logic [PHASE_W-1:0] v);
    return v + PHASE_STEP;
  endfunction

  function automatic logic [FTW_W-1:0] ftw_of(input logic [1:0] fidx);
    return FTW_BASE << fidx;
  endfunction

  logic [3:0]         key_acc;
  logic [3:0]         acc_vec;
  logic [1:0]         wave_sh;
  logic [1:0]         amp_sh;
  logic [PHASE_W-1:0] phase_sh;
  logic [1:0]         fidx_sh;
  logic [TO_W-1:0]    timer;
  cfg_state_e         state;

  dds_key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_key_w (
    .clk(clk), .rst_n(rst_n), .key_raw(W_ctrl), .key_acc(key_acc[KEY_W]));
  dds_key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_key_a (
    .clk(clk), .rst_n(rst_n), .key_raw(A_ctrl), .key_acc(key_acc[KEY_A]));
  dds_key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_key_p (
    .clk(clk), .rst_n(rst_n), .key_raw(P_ctrl), .key_acc(key_acc[KEY_P]));
  dds_key_filter #(.DEB_CYCLES(DEB_CYCLES)) u_key_f (
    .clk(clk), .rst_n(rst_n), .key_raw(F_ctrl), .key_acc(key_acc[KEY_F]));

`ifdef DDS_CFG_CTRL_SWEEP_EN
  localparam int SW_W = $clog2(SWEEP_WRAPS + 1);

  logic [SW_W-1:0] sweep_cnt;
  logic            sweep_acc;

  // Every SWEEP_WRAPS wraps the sweep injects an F accept into the normal path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
      sweep_acc <= 1'b0;
    end else begin
      sweep_acc <= 1'b0;
      if (!sweep_en) begin
        sweep_cnt <= '0;
      end else if (acc_wrap) begin
        if (sweep_cnt == SW_W'(SWEEP_WRAPS - 1)) begin
          sweep_cnt <= '0;
          sweep_acc <= 1'b1;
        end else begin
          sweep_cnt <= sweep_cnt + 1'b1;
        end
      end
    end
  end

  assign acc_vec = {key_acc[KEY_F] | sweep_acc, key_acc[KEY_P], key_acc[KEY_A], key_acc[KEY_W]};
`else
  assign acc_vec = key_acc;
`endif

  // Shadow configuration, updated the cycle after each accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wave_sh  <= WAVE_SINE;
      amp_sh   <= 2'd0;
      phase_sh <= '0;
      fidx_sh  <= 2'd0;
    end else begin
      if (acc_vec[KEY_W]) wave_sh  <= sel_next(wave_sh);
      if (acc_vec[KEY_A]) amp_sh   <= sel_next(amp_sh);
      if (acc_vec[KEY_P]) phase_sh <= phase_next(phase_sh);
      if (acc_vec[KEY_F]) fidx_sh  <= sel_next(fidx_sh);
    end
  end

  // Commit FSM: the copy in COMMIT reads the shadow before any same-cycle accept lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      cfg_pending <= 1'b0;
      cfg_upd     <= 1'b0;
      wave_sel    <= WAVE_SINE;
      amp_shift   <= 2'd0;
      phase_word  <= '0;
      freq_word   <= FTW_BASE;
    end else begin
      cfg_upd <= 1'b0;
      case (state)
        IDLE: begin
          if (|acc_vec) begin
            state       <= WAIT_WRAP;
            cfg_pending <= 1'b1;
            timer       <= '0;
          end
        end
        WAIT_WRAP: begin
          if (acc_wrap || timer == TO_LAST) begin
            state <= COMMIT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        COMMIT: begin
          wave_sel   <= wave_sh;
          amp_shift  <= amp_sh;
          phase_word <= phase_sh;
          freq_word  <= ftw_of(fidx_sh);
          cfg_upd    <= 1'b1;
          if (|acc_vec) begin
            state <= WAIT_WRAP;
            timer <= '0;
          end else begin
            state       <= IDLE;
            cfg_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
